dfp_bcd_div_core: RTL and testbench

- Sequential BCD significand divider for the 96-bit decimal FP divide path.
- Sits between the operand-register stage and the result-assembly/exponent stage.
- Produces the 2N-digit quotient floor(a*10^N / b), an N-digit remainder, and a BCD leading-zero-digit count. The downstream stage uses the count to normalize the quotient and adjust the exponent.
- Restoring digit recurrence with fixed latency: one shift cycle plus nine trial-subtract cycles per quotient digit.

---
 rtl/dfp_bcd_div_core_pkg.sv | 20 ++
 rtl/dfp_bcd_div_core_if.sv | 24 ++
 rtl/dfp_bcd_div_core_sub.sv | 33 +++
 rtl/dfp_bcd_div_core.sv | 150 +++++++++++++++
 tb/tb_dfp_bcd_div_core.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dfp_bcd_div_core_pkg.sv
// Shared types and constants for the BCD significand divider.
package dfp_bcd_div_core_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        TRIAL,
        FIN
    } dfp_div_state_t;

    localparam int unsigned DFP_DIV_TRIALS = 9;

    // Binary count (< 100) to two BCD digits, tens digit in the upper nibble.
    function automatic logic [7:0] bin7_to_bcd(input logic [6:0] bin);
        return {4'(bin / 7'd10), 4'(bin % 7'd10)};
    endfunction

endpackage

// File: rtl/dfp_bcd_div_core_if.sv
// Operand/result bundle between the operand-register stage and the divider core.
interface dfp_bcd_div_core_if #(
    parameter int unsigned N = 27
);
    logic                 ce;
    logic                 ld;
    logic [N*4-1:0]       a;
    logic [N*4-1:0]       b;
    logic [2*N*4-1:0]     q;
    logic [N*4-1:0]       r;
    logic [7:0]           lzcnt;
    logic                 done;
    logic                 dbz;

    modport master (
        output ce, ld, a, b,
        input  q, r, lzcnt, done, dbz
    );

    modport slave (
        input  ce, ld, a, b,
        output q, r, lzcnt, done, dbz
    );
endinterface

// File: rtl/dfp_bcd_div_core_sub.sv
// D-digit BCD subtractor; borrow_o=0 means x_i >= y_i, so the same chain
// serves as the magnitude compare for the trial step.
module dfp_bcd_sub #(
    parameter int unsigned D = 28
) (
    input  logic [D*4-1:0] x_i,
    input  logic [D*4-1:0] y_i,
    output logic [D*4-1:0] diff_o,
    output logic           borrow_o
);

    logic [4:0] dig_t;
    logic       brw;

    // Ripple digit-wise subtract, correcting negative digits by +10.
    always_comb begin
        diff_o = '0;
        brw    = 1'b0;
        dig_t  = '0;
        for (int unsigned i = 0; i < D; i++) begin
            dig_t = {1'b0, x_i[i*4 +: 4]} - {1'b0, y_i[i*4 +: 4]} - {4'd0, brw};
            if (dig_t[4]) begin
                diff_o[i*4 +: 4] = dig_t[3:0] + 4'd10;
                brw              = 1'b1;
            end else begin
                diff_o[i*4 +: 4] = dig_t[3:0];
                brw              = 1'b0;
            end
        end
        borrow_o = brw;
    end

endmodule

// File: rtl/dfp_bcd_div_core.sv
// Restoring BCD significand divider: q = floor(a*10^N / b), r = remainder,
// lzcnt = BCD count of leading zero quotient digits. One shift plus nine
// trial-subtract cycles per quotient digit, 2N digits.
module dfp_bcd_div_core
    import dfp_bcd_div_core_pkg::*;
#(
    parameter int unsigned N = 27
) (
    input  logic                 clk,
    input  logic                 rst,
    dfp_bcd_div_core_if.slave    div_if
);

    localparam int unsigned QD = 2 * N;
    localparam int unsigned W  = N * 4;
    localparam int unsigned QW = QD * 4;
    localparam int unsigned RW = (N + 1) * 4;

    dfp_div_state_t  state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [QW-1:0]   dvd_q;
    logic [QW-1:0]   acc_q;
    logic [RW-1:0]   rem_q;
    bcd_digit_t      qdig_q;
    logic [3:0]      trial_q;
    logic [6:0]      idx_q;
    logic [QW-1:0]   q_q;
    logic [W-1:0]    r_q;
    logic [7:0]      lz_q;
    logic            done_q;
    logic            dbz_q;

    logic [RW-1:0]   sub_diff;
    logic            sub_borrow;
    bcd_digit_t      qdig_d;
    logic [6:0]      lz_bin;
    logic            lz_found;
    logic [7:0]      lz_bcd;
    logic            start;
    logic            trial_last;

    dfp_bcd_sub #(
        .D(N + 1)
    ) u_sub (
        .x_i      (rem_q),
        .y_i      ({4'h0, b_q}),
        .diff_o   (sub_diff),
        .borrow_o (sub_borrow)
    );

    // Quotient digit after this trial, and restart/trial-end decodes.
    always_comb begin
        qdig_d     = sub_borrow ? qdig_q : qdig_q + 4'd1;
        start      = div_if.ld && (state_q != FIN);
        trial_last = (trial_q == 4'(DFP_DIV_TRIALS - 1));
    end

    // Leading-zero digit count of the finished quotient accumulator.
    always_comb begin
        lz_bin   = '0;
        lz_found = 1'b0;
        for (int unsigned j = 0; j < QD; j++) begin
            if (!lz_found && (acc_q[(QD-1-j)*4 +: 4] == 4'h0)) begin
                lz_bin = lz_bin + 7'd1;
            end else begin
                lz_found = 1'b1;
            end
        end
        lz_bcd = bin7_to_bcd(lz_bin);
    end

    // Divider FSM with registered results; ld in any state but FIN restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            dvd_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            qdig_q  <= '0;
            trial_q <= '0;
            idx_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            lz_q    <= '0;
            done_q  <= 1'b1;
            dbz_q   <= 1'b0;
        end else if (div_if.ce) begin
            if (start) begin
                a_q     <= div_if.a;
                b_q     <= div_if.b;
                dvd_q   <= {div_if.a, {W{1'b0}}};
                acc_q   <= '0;
                rem_q   <= '0;
                qdig_q  <= '0;
                trial_q <= '0;
                idx_q   <= 7'(QD - 1);
                done_q  <= 1'b0;
                dbz_q   <= (div_if.b == '0);
                state_q <= SHIFT;
            end else begin
                case (state_q)
                    SHIFT: begin
                        rem_q   <= {rem_q[W-1:0], dvd_q[QW-1 -: 4]};
                        dvd_q   <= {dvd_q[QW-5:0], 4'h0};
                        qdig_q  <= '0;
                        trial_q <= '0;
                        state_q <= TRIAL;
                    end
                    TRIAL: begin
                        if (!sub_borrow) begin
                            rem_q <= sub_diff;
                        end
                        qdig_q <= qdig_d;
                        if (trial_last) begin
                            acc_q <= {acc_q[QW-5:0], qdig_d};
                            if (idx_q == '0) begin
                                state_q <= FIN;
                            end else begin
                                idx_q   <= idx_q - 7'd1;
                                state_q <= SHIFT;
                            end
                        end else begin
                            trial_q <= trial_q + 4'd1;
                        end
                    end
                    FIN: begin
                        q_q     <= acc_q;
                        r_q     <= dbz_q ? a_q : rem_q[W-1:0];
                        lz_q    <= lz_bcd;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign div_if.q     = q_q;
    assign div_if.r     = r_q;
    assign div_if.lzcnt = lz_q;
    assign div_if.done  = done_q;
    assign div_if.dbz   = dbz_q;

endmodule

// File: tb/tb_dfp_bcd_div_core.sv
// Self-checking bench: directed N=4 cases plus random N=27 divides against a
// wide-integer reference model.
`timescale 1ns/1ps
module tb_dfp_bcd_div_core;

    logic clk;
    logic rst;

    dfp_bcd_div_core_if #(.N(4))  if4 ();
    dfp_bcd_div_core_if #(.N(27)) if27 ();

    dfp_bcd_div_core #(.N(4)) dut4 (
        .clk    (clk),
        .rst    (rst),
        .div_if (if4)
    );

    dfp_bcd_div_core #(.N(27)) dut27 (
        .clk    (clk),
        .rst    (rst),
        .div_if (if27)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer long division of a*10^n by b, then back to BCD.
    function automatic void ref_div(input int unsigned n, input logic [107:0] a,
                                    input logic [107:0] b, output logic [215:0] q,
                                    output logic [107:0] r, output logic [7:0] lz,
                                    output bit dbz);
        logic [255:0] av, bv, num, qv, rv;
        int unsigned cnt;
        bit found;
        av = '0;
        bv = '0;
        for (int unsigned i = 0; i < n; i++) begin
            av = av * 10 + 256'(a[(n-1-i)*4 +: 4]);
            bv = bv * 10 + 256'(b[(n-1-i)*4 +: 4]);
        end
        q   = '0;
        r   = '0;
        dbz = (bv == 0);
        if (dbz) begin
            for (int unsigned i = 0; i < 2*n; i++) q[i*4 +: 4] = 4'd9;
            r = a;
        end else begin
            num = av;
            for (int unsigned i = 0; i < n; i++) num = num * 10;
            qv = num / bv;
            rv = num % bv;
            for (int unsigned i = 0; i < 2*n; i++) begin
                q[i*4 +: 4] = 4'(qv % 10);
                qv = qv / 10;
            end
            for (int unsigned i = 0; i < n; i++) begin
                r[i*4 +: 4] = 4'(rv % 10);
                rv = rv / 10;
            end
        end
        cnt = 0;
        found = 0;
        for (int unsigned i = 0; i < 2*n; i++) begin
            if (!found && q[(2*n-1-i)*4 +: 4] == 4'd0) cnt++;
            else found = 1;
        end
        lz = {4'(cnt / 10), 4'(cnt % 10)};
    endfunction

    // Model state per DUT (0: N=4, 1: N=27)
    bit           m_valid [2];
    bit           m_busy  [2];
    int unsigned  m_cnt   [2];
    int unsigned  m_lat   [2];
    logic [215:0] m_pend_q [2], m_pub_q [2];
    logic [107:0] m_pend_r [2], m_pub_r [2];
    logic [7:0]   m_pend_lz[2], m_pub_lz[2];
    bit           m_pend_dbz[2], m_pub_dbz[2];

    logic         mc_ce, mc_ld;
    logic [107:0] mc_a, mc_b;
    int unsigned  mc_n;

    initial begin
        m_lat[0] = 20*4 + 1;
        m_lat[1] = 20*27 + 1;
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 0;
            m_busy[d]  = 0;
            m_cnt[d]   = 0;
        end
    end

    // Model advance on each active edge, from the inputs presented at that edge.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                mc_ce = if4.ce;  mc_ld = if4.ld;
                mc_a = 108'(if4.a); mc_b = 108'(if4.b); mc_n = 4;
            end else begin
                mc_ce = if27.ce; mc_ld = if27.ld;
                mc_a = if27.a; mc_b = if27.b; mc_n = 27;
            end
            if (rst) begin
                m_valid[d]   = 1;
                m_busy[d]    = 0;
                m_pub_q[d]   = '0;
                m_pub_r[d]   = '0;
                m_pub_lz[d]  = '0;
                m_pub_dbz[d] = 0;
            end else if (mc_ce) begin
                if (mc_ld && !(m_busy[d] && m_cnt[d] == m_lat[d] - 1)) begin
                    m_busy[d] = 1;
                    m_cnt[d]  = 0;
                    ref_div(mc_n, mc_a, mc_b, m_pend_q[d], m_pend_r[d], m_pend_lz[d], m_pend_dbz[d]);
                end else if (m_busy[d]) begin
                    m_cnt[d]++;
                    if (m_cnt[d] == m_lat[d]) begin
                        m_busy[d]    = 0;
                        m_pub_q[d]   = m_pend_q[d];
                        m_pub_r[d]   = m_pend_r[d];
                        m_pub_lz[d]  = m_pend_lz[d];
                        m_pub_dbz[d] = m_pend_dbz[d];
                    end
                end
            end
        end
    end

    // Compare both DUTs against the model every cycle.
    always @(negedge clk) begin
        logic [255:0] aq, ar, alz;
        logic adone, adbz;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                aq = 256'(if4.q); ar = 256'(if4.r); alz = 256'(if4.lzcnt);
                adone = if4.done; adbz = if4.dbz;
            end else begin
                aq = 256'(if27.q); ar = 256'(if27.r); alz = 256'(if27.lzcnt);
                adone = if27.done; adbz = if27.dbz;
            end
            if (m_valid[d]) begin
                chk($sformatf("d%0d_done", d), 256'(adone), 256'(!m_busy[d]));
                chk($sformatf("d%0d_q", d), aq, 256'(m_pub_q[d]));
                chk($sformatf("d%0d_r", d), ar, 256'(m_pub_r[d]));
                chk($sformatf("d%0d_lz", d), alz, 256'(m_pub_lz[d]));
                if (!m_busy[d])
                    chk($sformatf("d%0d_dbz", d), 256'(adbz), 256'(m_pub_dbz[d]));
            end
        end
    end

    localparam int LIMIT = 2000;

    task automatic start4(input logic [15:0] a, input logic [15:0] b);
        if4.a  = a;
        if4.b  = b;
        if4.ld = 1'b1;
        @(negedge clk);
        if4.ld = 1'b0;
    endtask

    task automatic start27(input logic [107:0] a, input logic [107:0] b);
        if27.a  = a;
        if27.b  = b;
        if27.ld = 1'b1;
        @(negedge clk);
        if27.ld = 1'b0;
    endtask

    task automatic wait_done(input int sel, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (((sel == 0) ? !if4.done : !if27.done) && cyc < LIMIT);
    endtask

    task automatic chk4(input string name, input logic [31:0] q, input logic [15:0] r,
                        input logic [7:0] lz, input logic dbz);
        chk({name, "_q"},   256'(if4.q),     256'(q));
        chk({name, "_r"},   256'(if4.r),     256'(r));
        chk({name, "_lz"},  256'(if4.lzcnt), 256'(lz));
        chk({name, "_dbz"}, 256'(if4.dbz),   256'(dbz));
        chk({name, "_done"}, 256'(if4.done), 256'(1'b1));
    endtask

    initial begin
        logic [215:0] pq;
        logic [107:0] pr, a27, b27;
        logic [7:0]   plz;
        bit           pdbz;
        int           cyc, stalls, k;

        rst = 1'b1;
        if4.ce = 1'b1;  if4.ld = 1'b0;  if4.a = '0;  if4.b = '0;
        if27.ce = 1'b1; if27.ld = 1'b0; if27.a = '0; if27.b = '0;

        // Pin the reference model with hand-computed results.
        ref_div(4, 108'h0001, 108'h0003, pq, pr, plz, pdbz);
        chk("pin_1div3_q", 256'(pq), 256'h00003333);
        chk("pin_1div3_lz", 256'(plz), 256'h04);
        ref_div(4, 108'h0001, 108'h0007, pq, pr, plz, pdbz);
        chk("pin_1div7_q", 256'(pq), 256'h00001428);
        chk("pin_1div7_r", 256'(pr), 256'h0004);
        ref_div(4, 108'h0042, 108'h0000, pq, pr, plz, pdbz);
        chk("pin_dbz_q", 256'(pq), 256'h99999999);
        chk("pin_dbz_flag", 256'(pdbz), 256'h1);

        repeat (3) @(negedge clk);
        chk4("reset", 32'h0, 16'h0, 8'h00, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Divide, then a second divide with new operands.
        start4(16'h0001, 16'h0003);
        wait_done(0, cyc);
        chk("lat_1div3", 256'(cyc), 256'(81));
        chk4("div_1_3", 32'h00003333, 16'h0001, 8'h04, 1'b0);
        start4(16'h9999, 16'h0001);
        wait_done(0, cyc);
        chk("lat_9999", 256'(cyc), 256'(81));
        chk4("div_9999_1", 32'h99990000, 16'h0000, 8'h00, 1'b0);

        // Divide by zero.
        start4(16'h0042, 16'h0000);
        wait_done(0, cyc);
        chk("lat_dbz", 256'(cyc), 256'(81));
        chk4("dbz", 32'h99999999, 16'h0042, 8'h00, 1'b1);

        // Clock-enable stalls: 13 ce-low cycles somewhere in the first 50.
        start4(16'h0001, 16'h0007);
        stalls = 13;
        cyc = 0;
        while (!if4.done && cyc < LIMIT) begin
            if (stalls > 0 && cyc >= 2 && ($urandom_range(0, 1) == 1 || stalls >= 50 - cyc)) begin
                if4.ce = 1'b0;
                stalls--;
            end else begin
                if4.ce = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        if4.ce = 1'b1;
        chk("lat_stall", 256'(cyc), 256'(81 + 13));
        chk4("stall_1_7", 32'h00001428, 16'h0004, 8'h04, 1'b0);

        // Abort by a new ld 30 edges into an operation.
        start4(16'h0001, 16'h0003);
        repeat (29) @(negedge clk);
        start4(16'h0008, 16'h0002);
        wait_done(0, cyc);
        chk("lat_abort_ld", 256'(cyc), 256'(81));
        chk4("abort_8_2", 32'h00040000, 16'h0000, 8'h03, 1'b0);

        // Abort by reset at edge 40, then a normal divide.
        start4(16'h0001, 16'h0003);
        repeat (39) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk4("abort_rst", 32'h0, 16'h0, 8'h00, 1'b0);
        start4(16'h0001, 16'h0007);
        wait_done(0, cyc);
        chk("lat_after_rst", 256'(cyc), 256'(81));
        chk4("after_rst", 32'h00001428, 16'h0004, 8'h04, 1'b0);

        // N=27 random operands; results checked by the model process.
        for (int t = 0; t < 100; t++) begin
            a27 = '0;
            b27 = '0;
            for (int i = 0; i < 27; i++) begin
                a27[i*4 +: 4] = 4'($urandom_range(0, 9));
                b27[i*4 +: 4] = 4'($urandom_range(0, 9));
            end
            k = $urandom_range(0, 26);
            for (int i = 0; i < 27; i++)
                if (i >= 27 - k) b27[i*4 +: 4] = 4'd0;
            if (b27 == '0) b27[3:0] = 4'd1;
            start27(a27, b27);
            wait_done(1, cyc);
            chk("lat_n27", 256'(cyc), 256'(541));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
